// File: rtl/log_expand.sv
// -----------------------------------------------------------------------------
// log_expand
//   Rebuilds linear magnitudes from log2-domain codes produced by the envelope
//   log compressor. A code {int, frac} is expanded as 2^(int.frac) using the
//   Mitchell approximation 2^f ~= 1 + f, i.e. value = ((1.frac) << int).
//   Codes whose integer part cannot be represented in DATA_WIDTH bits are
//   clamped to all ones and flagged. A saturating counter tallies the number
//   of clamped samples actually handed to the downstream consumer.
//
//   Three-stage valid/ready pipeline:
//     S1  split the code into exponent, mantissa {1,frac} and saturation flag
//     S2  shift the mantissa into place, or substitute the clamp value
//     S3  output register
//   All stages advance together whenever the output is free or being taken.
//
// Ports
//   clk        in   1            clock
//   reset      in   1            synchronous, active-high reset
//   in_valid   in   1            log_in is valid
//   in_ready   out  1            block accepts log_in this cycle
//   log_in     in   COMP_WIDTH   unsigned code {int[SHIFT_WIDTH-1:0], frac[FRAC_BITS-1:0]}
//   out_valid  out  1            data_out/sat_flag are valid
//   out_ready  in   1            downstream accepts data_out
//   data_out   out  DATA_WIDTH   reconstructed linear magnitude
//   sat_flag   out  1            data_out was clamped for this sample
//   sat_count  out  CNT_WIDTH    saturated samples delivered, sticky at max
// -----------------------------------------------------------------------------
module log_expand #(
  parameter int DATA_WIDTH  = 48,
  parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH),
  parameter int COMP_WIDTH  = 15,
  parameter int FRAC_BITS   = COMP_WIDTH - SHIFT_WIDTH,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [COMP_WIDTH-1:0] log_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  sat_flag,
  output logic [CNT_WIDTH-1:0]  sat_count
);

  // Exponent compare is done one bit wider so DATA_WIDTH itself is representable.
  localparam logic [SHIFT_WIDTH:0]   SAT_THRESH = (SHIFT_WIDTH+1)'(DATA_WIDTH);
  localparam logic [SHIFT_WIDTH-1:0] FRAC_SHIFT = SHIFT_WIDTH'(FRAC_BITS);
  localparam logic [DATA_WIDTH-1:0]  SAT_VALUE  = {DATA_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]   CNT_MAX    = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE    = CNT_WIDTH'(1);

  // Global advance enable shared by every stage.
  logic en_s;

  // Input code fields.
  logic [SHIFT_WIDTH-1:0] code_int_s;
  logic [FRAC_BITS-1:0]   code_frac_s;

  // Stage 1 registers.
  logic                   s1_valid_q, s1_valid_d;
  logic [SHIFT_WIDTH-1:0] s1_exp_q,   s1_exp_d;
  logic [FRAC_BITS:0]     s1_mant_q,  s1_mant_d;
  logic                   s1_sat_q,   s1_sat_d;

  // Stage 2 datapath and registers.
  logic [DATA_WIDTH-1:0]  mant_ext_s;
  logic [DATA_WIDTH-1:0]  prod_s;
  logic                   s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0]  s2_prod_q,  s2_prod_d;
  logic                   s2_sat_q,   s2_sat_d;

  // Stage 3 (output) registers.
  logic                   s3_valid_q, s3_valid_d;
  logic [DATA_WIDTH-1:0]  s3_data_q,  s3_data_d;
  logic                   s3_sat_q,   s3_sat_d;

  // Saturation event counter.
  logic [CNT_WIDTH-1:0]   sat_cnt_q,  sat_cnt_d;

  // The pipeline moves when the output slot is empty or being consumed.
  assign en_s     = out_ready | ~s3_valid_q;
  assign in_ready = en_s;

  assign code_int_s  = log_in[COMP_WIDTH-1 -: SHIFT_WIDTH];
  assign code_frac_s = log_in[FRAC_BITS-1:0];

  // Stage 1 next state: decode the code into exponent, mantissa and clamp flag.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_exp_d   = s1_exp_q;
    s1_mant_d  = s1_mant_q;
    s1_sat_d   = s1_sat_q;
    if (en_s) begin
      s1_valid_d = in_valid;
      s1_exp_d   = code_int_s;
      s1_mant_d  = {1'b1, code_frac_s};
      s1_sat_d   = ({1'b0, code_int_s} >= SAT_THRESH);
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2 datapath: (M << e) >> FRAC_BITS, done as a single left or right
  // shift so no bits beyond DATA_WIDTH are ever materialised. For e below
  // FRAC_BITS the fraction is truncated toward zero by the right shift.
  always_comb begin
    mant_ext_s = {{(DATA_WIDTH-FRAC_BITS-1){1'b0}}, s1_mant_q};
    prod_s     = '0;
    if (s1_sat_q) begin
      prod_s = SAT_VALUE;
    end else if (s1_exp_q >= FRAC_SHIFT) begin
      prod_s = mant_ext_s << (s1_exp_q - FRAC_SHIFT);
    end else begin
      prod_s = mant_ext_s >> (FRAC_SHIFT - s1_exp_q);
    end
  end

  // Stage 2 next state: register the expanded magnitude.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_prod_d  = s2_prod_q;
    s2_sat_d   = s2_sat_q;
    if (en_s) begin
      s2_valid_d = s1_valid_q;
      s2_prod_d  = prod_s;
      s2_sat_d   = s1_sat_q;
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Stage 3 next state: output register, held while the consumer stalls.
  always_comb begin
    s3_valid_d = s3_valid_q;
    s3_data_d  = s3_data_q;
    s3_sat_d   = s3_sat_q;
    if (en_s) begin
      s3_valid_d = s2_valid_q;
      s3_data_d  = s2_prod_q;
      s3_sat_d   = s2_sat_q;
    end else begin
      s3_valid_d = s3_valid_q;
    end
  end

  // Counter next state: count clamped samples on actual delivery, stick at max.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (s3_valid_q && out_ready && s3_sat_q && (sat_cnt_q != CNT_MAX)) begin
      sat_cnt_d = sat_cnt_q + CNT_ONE;
    end else begin
      sat_cnt_d = sat_cnt_q;
    end
  end

  // Pipeline and counter state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_exp_q   <= '0;
      s1_mant_q  <= '0;
      s1_sat_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_prod_q  <= '0;
      s2_sat_q   <= 1'b0;
      s3_valid_q <= 1'b0;
      s3_data_q  <= '0;
      s3_sat_q   <= 1'b0;
      sat_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_exp_q   <= s1_exp_d;
      s1_mant_q  <= s1_mant_d;
      s1_sat_q   <= s1_sat_d;
      s2_valid_q <= s2_valid_d;
      s2_prod_q  <= s2_prod_d;
      s2_sat_q   <= s2_sat_d;
      s3_valid_q <= s3_valid_d;
      s3_data_q  <= s3_data_d;
      s3_sat_q   <= s3_sat_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  assign out_valid = s3_valid_q;
  assign data_out  = s3_data_q;
  assign sat_flag  = s3_sat_q;
  assign sat_count = sat_cnt_q;

endmodule
